// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths, FSM state encoding and address field extraction
// for the direct-mapped write-back data cache.
`ifndef DCACHE_PKG_MACROS
`define DCACHE_PKG_MACROS
`define DC_TAG(a) a[dcache_pkg::ADDR_W-1 -: dcache_pkg::TAG_W]
`define DC_IDX(a) a[dcache_pkg::OFFSET_W +: dcache_pkg::INDEX_W]
`define DC_OFF(a) a[dcache_pkg::OFFSET_W-1:0]
`endif

package dcache_pkg;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int INDEX_W  = 6;
    localparam int OFFSET_W = 2;

    localparam int unsigned WORDS = 4;
    localparam int LINE_W = 4 * DATA_W;
    localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES  = 1 << INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRBACK = 2'd1,
        S_FILL   = 2'd2
    } state_t;
endpackage

// File: rtl/dcache_array.sv
// dcache_array: per-line {valid, dirty, tag, data} storage with one combinational
// read port and one synchronous write port (word-masked store or full-line fill).
module dcache_array
    import dcache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] i_ridx,
    output logic               o_valid,
    output logic               o_dirty,
    output logic [TAG_W-1:0]   o_tag,
    output logic [LINE_W-1:0]  o_line,
    input  logic [INDEX_W-1:0] i_widx,
    input  logic [WORDS-1:0]   i_wmask,
    input  logic [DATA_W-1:0]  i_wword,
    input  logic               i_fill,
    input  logic [TAG_W-1:0]   i_ftag,
    input  logic [LINE_W-1:0]  i_fline
);
    logic [LINES-1:0]  r_valid;
    logic [LINES-1:0]  r_dirty;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [LINE_W-1:0] r_line [LINES];

    always_comb begin
        o_valid = r_valid[i_ridx];
        o_dirty = r_dirty[i_ridx];
        o_tag   = r_tag[i_ridx];
        o_line  = r_line[i_ridx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill) begin
            r_valid[i_widx] <= 1'b1;
            r_dirty[i_widx] <= 1'b0;
        end else if (|i_wmask) begin
            r_dirty[i_widx] <= 1'b1;
        end
    end

    // Tag and data carry no reset so they can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (i_fill) begin
            r_tag[i_widx]  <= i_ftag;
            r_line[i_widx] <= i_fline;
        end else begin
            for (int unsigned w = 0; w < WORDS; w++) begin
                if (i_wmask[w]) begin
                    r_line[i_widx][w*DATA_W +: DATA_W] <= i_wword;
                end
            end
        end
    end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back/write-allocate data cache controller.
// Optional hit/miss counters are built when DCACHE_PERF_CNT_EN is defined.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_rdy
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);
    state_t               r_state;
    logic [TAG_W-1:0]     r_tag;
    logic [INDEX_W-1:0]   r_idx;

    logic                 w_valid, w_dirty;
    logic [TAG_W-1:0]     w_vtag;
    logic [LINE_W-1:0]    w_line;
    logic [TAG_W-1:0]     w_tag;
    logic [INDEX_W-1:0]   w_idx;
    logic [OFFSET_W-1:0]  w_off;
    logic                 w_req, w_hit, w_idle, w_miss, w_done, w_fill;
    logic [WORDS-1:0]     w_wmask;
    logic [INDEX_W-1:0]   w_widx;

    assign w_tag = `DC_TAG(cpu_addr);
    assign w_idx = `DC_IDX(cpu_addr);
    assign w_off = `DC_OFF(cpu_addr);

    dcache_array u_array (
        .clk     (clk),
        .rst     (rst),
        .i_ridx  (w_idx),
        .o_valid (w_valid),
        .o_dirty (w_dirty),
        .o_tag   (w_vtag),
        .o_line  (w_line),
        .i_widx  (w_widx),
        .i_wmask (w_wmask),
        .i_wword (cpu_wdata),
        .i_fill  (w_fill),
        .i_ftag  (r_tag),
        .i_fline (mem_rdata)
    );

    always_comb begin
        w_req     = cpu_rd | cpu_wr;
        w_hit     = w_valid && (w_vtag == w_tag);
        w_idle    = (r_state == S_IDLE);
        w_miss    = w_idle & w_req & ~w_hit;
        w_done    = w_idle & w_req & w_hit;
        w_fill    = (r_state == S_FILL) & mem_rdy;
        w_widx    = w_fill ? r_idx : w_idx;
        w_wmask   = (w_done & cpu_wr) ? ({{(WORDS-1){1'b0}}, 1'b1} << w_off) : '0;
        cpu_stall = w_miss | ~w_idle;
        cpu_rdata = (w_done & cpu_rd & ~cpu_wr) ? w_line[w_off*DATA_W +: DATA_W] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_tag     <= '0;
            r_idx     <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_tag <= w_tag;
                        r_idx <= w_idx;
                        if (w_valid & w_dirty) begin
                            r_state   <= S_WRBACK;
                            mem_wr    <= 1'b1;
                            mem_addr  <= {w_vtag, w_idx, {OFFSET_W{1'b0}}};
                            mem_wdata <= w_line;
                        end else begin
                            r_state  <= S_FILL;
                            mem_rd   <= 1'b1;
                            mem_addr <= {w_tag, w_idx, {OFFSET_W{1'b0}}};
                        end
                    end
                end
                S_WRBACK: begin
                    if (mem_rdy) begin
                        r_state  <= S_FILL;
                        mem_wr   <= 1'b0;
                        mem_rd   <= 1'b1;
                        mem_addr <= {r_tag, r_idx, {OFFSET_W{1'b0}}};
                    end
                end
                S_FILL: begin
                    if (mem_rdy) begin
                        r_state <= S_IDLE;
                        mem_rd  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic r_missed;

    // A request that stalled at any point is counted as a miss when it finally hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            r_missed <= 1'b0;
        end else if (w_miss) begin
            r_missed <= 1'b1;
        end else if (w_done) begin
            r_missed <= 1'b0;
            if (r_missed) miss_cnt <= miss_cnt + 32'd1;
            else          hit_cnt  <= hit_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench; a behavioural cache/memory model predicts read
// data, stall lengths and memory transactions, checked against a latency-N memory.
module tb_dcache_ctrl;
    localparam int MEM_N = 3;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [63:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_stall, mem_rd, mem_wr;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        mem_rdy = 1'b0;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
    int          exp_hit = 0, exp_miss = 0;
`endif

    dcache_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model memory (mm) follows the spec; bus memory (bm) is what the responder serves.
    logic [15:0] mm [65536];
    logic [15:0] bm [65536];
    bit          mv [64];
    bit          md [64];
    logic [7:0]  mtag [64];
    logic [15:0] mline [64][4];
    txn_t        exp_mem[$];
    logic [15:0] exp_rd[$];
    bit          hold = 1'b0;
    int          stray_req = 0;

    initial begin : responder
        int          lat;
        int          stray_done;
        txn_t        t;
        logic [63:0] line;
        lat = 0;
        stray_done = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_rdy = 1'b0;
            if (stray_req != stray_done) begin
                stray_done = stray_req;
                mem_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
                mem_rdy    = 1'b1;
            end else if (rst || hold || !(mem_rd || mem_wr)) begin
                lat = 0;
            end else begin
                chk("mem_excl", 64'(mem_rd & mem_wr), 64'd0);
                lat++;
                if (lat == MEM_N) begin
                    lat = 0;
                    if (exp_mem.size() == 0) begin
                        chk("mem_unexpected", 64'd1, 64'd0);
                    end else begin
                        t = exp_mem.pop_front();
                        chk("mem_kind", 64'(mem_wr), 64'(t.wr));
                        chk("mem_addr", 64'(mem_addr), 64'(t.addr));
                        if (t.wr) chk("mem_wdata", mem_wdata, t.data);
                    end
                    if (mem_wr) begin
                        for (int w = 0; w < 4; w++)
                            bm[{mem_addr[15:2], 2'(w)}] = mem_wdata[w*16 +: 16];
                    end else begin
                        for (int w = 0; w < 4; w++)
                            line[w*16 +: 16] = bm[{mem_addr[15:2], 2'(w)}];
                        mem_rdata = line;
                    end
                    mem_rdy = 1'b1;
                end
            end
        end
    end

    task automatic access(input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [15:0] wdata);
        int          idx, off, exp_stall, cnt;
        logic [7:0]  tag;
        logic [63:0] vl;
        txn_t        t;
        idx = int'(addr[7:2]);
        off = int'(addr[1:0]);
        tag = addr[15:8];
        if (mv[idx] && mtag[idx] == tag) begin
            exp_stall = 0;
        end else begin
            if (mv[idx] && md[idx]) begin
                for (int w = 0; w < 4; w++) begin
                    vl[w*16 +: 16] = mline[idx][w];
                    mm[{mtag[idx], addr[7:2], 2'(w)}] = mline[idx][w];
                end
                t.wr = 1'b1;
                t.addr = {mtag[idx], addr[7:2], 2'b00};
                t.data = vl;
                exp_mem.push_back(t);
                exp_stall = 2 * MEM_N + 1;
            end else begin
                exp_stall = MEM_N + 1;
            end
            t.wr = 1'b0;
            t.addr = {addr[15:2], 2'b00};
            t.data = '0;
            exp_mem.push_back(t);
            for (int w = 0; w < 4; w++) mline[idx][w] = mm[{addr[15:2], 2'(w)}];
            mv[idx] = 1'b1;
            md[idx] = 1'b0;
            mtag[idx] = tag;
        end
`ifdef DCACHE_PERF_CNT_EN
        if (exp_stall == 0) exp_hit++;
        else                exp_miss++;
`endif
        if (wr) begin
            mline[idx][off] = wdata;
            md[idx] = 1'b1;
        end else if (rd) begin
            exp_rd.push_back(mline[idx][off]);
        end

        @(negedge clk);
        cpu_rd = rd;
        cpu_wr = wr;
        cpu_addr = addr;
        cpu_wdata = wdata;
        #1;
        cnt = 0;
        while (cpu_stall && cnt <= 200) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        chk("stall_cycles", 64'(cnt), 64'(exp_stall));
        if (rd && !wr) chk("rdata", 64'(cpu_rdata), 64'(exp_rd.pop_front()));
        @(negedge clk);
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) begin
            mm[i] = 16'(i) ^ 16'h3C5A;
            bm[i] = mm[i];
        end
        for (int w = 0; w < 4; w++) begin
            mm[16'h0044 + 16'(w)] = 16'h000A + 16'(w);
            bm[16'h0044 + 16'(w)] = 16'h000A + 16'(w);
        end
        for (int i = 0; i < 64; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end

        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall", 64'(cpu_stall), 64'd0);
        chk("rst_mem_rd", 64'(mem_rd), 64'd0);
        chk("rst_mem_wr", 64'(mem_wr), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_rdata", 64'(cpu_rdata), 64'd0);
        rst = 1'b0;

        // Cold read, write hit and read-back, dirty eviction, write-allocate merge.
        access(1'b1, 1'b0, 16'h0045, 16'h0);
        access(1'b0, 1'b1, 16'h0046, 16'h1234);
        access(1'b1, 1'b0, 16'h0046, 16'h0);
        access(1'b1, 1'b0, 16'h1046, 16'h0);
        access(1'b0, 1'b1, 16'h2000, 16'hBEEF);
        access(1'b1, 1'b0, 16'h2000, 16'h0);
        access(1'b1, 1'b0, 16'h3000, 16'h0);
        access(1'b1, 1'b0, 16'h2000, 16'h0);

        @(negedge clk);
        #1;
        chk("idle_rdata", 64'(cpu_rdata), 64'd0);
        chk("idle_stall", 64'(cpu_stall), 64'd0);

        // Simultaneous read and write behaves as a store.
        access(1'b1, 1'b1, 16'h2001, 16'h5555);
        access(1'b1, 1'b0, 16'h2001, 16'h0);

        // Reset while a fill is outstanding, then a stray completion pulse.
        hold = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b1;
        cpu_addr = 16'h3085;
        repeat (3) @(negedge clk);
        #1;
        chk("rstfill_mem_rd", 64'(mem_rd), 64'd1);
        chk("rstfill_mem_addr", 64'(mem_addr), 64'h3084);
        rst = 1'b1;
        cpu_rd = 1'b0;
        @(negedge clk);
        #1;
        chk("rstfill_rd_drop", 64'(mem_rd), 64'd0);
        chk("rstfill_stall", 64'(cpu_stall), 64'd0);
        rst = 1'b0;
        hold = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
        stray_req++;
        repeat (3) @(negedge clk);
        #1;
        chk("stray_stall", 64'(cpu_stall), 64'd0);
        chk("stray_mem_rd", 64'(mem_rd), 64'd0);
        access(1'b1, 1'b0, 16'h3085, 16'h0);
        access(1'b1, 1'b0, 16'h0045, 16'h0);

        // Mixed traffic over a few aliasing lines.
        for (int i = 0; i < 40; i++) begin
            a = {8'($urandom_range(0, 2) * 16), 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 1) access(1'b0, 1'b1, a, 16'($urandom));
            else                           access(1'b1, 1'b0, a, 16'h0);
        end

`ifdef DCACHE_PERF_CNT_EN
        do_reset();
        exp_hit = 0;
        exp_miss = 0;
        #1;
        chk("perf_rst_hit", 64'(hit_cnt), 64'd0);
        chk("perf_rst_miss", 64'(miss_cnt), 64'd0);
        access(1'b1, 1'b0, 16'h0045, 16'h0);
        access(1'b1, 1'b0, 16'h0046, 16'h0);
        access(1'b0, 1'b1, 16'h0047, 16'h7777);
        access(1'b1, 1'b0, 16'h0044, 16'h0);
        access(1'b1, 1'b0, 16'h1045, 16'h0);
        #1;
        chk("perf_hit", 64'(hit_cnt), 64'(exp_hit));
        chk("perf_miss", 64'(miss_cnt), 64'(exp_miss));
        chk("perf_hit_3", 64'(hit_cnt), 64'd3);
        chk("perf_miss_2", 64'(miss_cnt), 64'd2);
        do_reset();
        #1;
        chk("perf_clr_hit", 64'(hit_cnt), 64'd0);
        chk("perf_clr_miss", 64'(miss_cnt), 64'd0);
`endif

        repeat (5) @(negedge clk);
        chk("mem_txn_left", 64'(exp_mem.size()), 64'd0);
        chk("rdata_left", 64'(exp_rd.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
